// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store memory port.
// FSM state encoding, queued request layout and default sizing.
package lsu_pkg;

  localparam int LSU_ADDR_W = 32;
  localparam int LSU_DATA_W = 32;
  localparam int LSU_DEPTH  = 1024;
  localparam int LSU_QDEPTH = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } lsu_state_e;

  typedef struct packed {
    logic                  we;
    logic [LSU_ADDR_W-1:0] addr;
    logic [LSU_DATA_W-1:0] wdata;
  } lsu_req_t;

endpackage

// File: rtl/lsu_mem_port_if.sv
// Request/response channel between a load/store master and lsu_mem_port.
// master drives requests and consumes responses; slave is the LSU side.
interface lsu_mem_port_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/lsu_req_fifo.sv
// Synchronous FIFO with full/empty flags; pop data is the combinational head.
// Push ignored when full, pop ignored when empty; push+pop together keeps count.
module lsu_req_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] pop_dat,
  output logic         full,
  output logic         empty
);

  // DEPTH is a power of two, so pointers wrap naturally.
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  store [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign pop_dat = store[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store initiator: queued requests become one-cycle strobed memory accesses.
// Latency 2 edges accept->rsp_valid; rsp_ready low stalls in RESP; LSU_BYTE_ADDR_EN selects byte addressing.
module lsu_mem_port
  import lsu_pkg::*;
#(
  parameter int ADDR_W = LSU_ADDR_W,
  parameter int DATA_W = LSU_DATA_W,
  parameter int DEPTH  = LSU_DEPTH,
  parameter int QDEPTH = LSU_QDEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  lsu_mem_port_if.slave     bus,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_write_en,
  output logic              mem_read_en,
  input  logic [DATA_W-1:0] mem_read
);

  lsu_state_e                      state;
  lsu_req_t                        push_dat;
  lsu_req_t                        head;
  logic [$bits(lsu_req_t)-1:0]     head_bits;
  logic                            full;
  logic                            empty;
  logic                            issue;
  logic [ADDR_W-1:0]               head_word;
  logic                            head_misal;
  logic                            head_err;
  logic                            acc_err;
  logic                            rsp_valid_q;
  logic [DATA_W-1:0]               rsp_rdata_q;
  logic                            rsp_err_q;

  assign bus.req_ready = !full;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

  assign push_dat.we    = bus.req_we;
  assign push_dat.addr  = LSU_ADDR_W'(bus.req_addr);
  assign push_dat.wdata = LSU_DATA_W'(bus.req_wdata);

  lsu_req_fifo #(
    .W     ($bits(lsu_req_t)),
    .DEPTH (QDEPTH)
  ) u_req_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (bus.req_valid && bus.req_ready),
    .push_dat (push_dat),
    .pop      (issue),
    .pop_dat  (head_bits),
    .full     (full),
    .empty    (empty)
  );

  assign head = lsu_req_t'(head_bits);

`ifdef LSU_BYTE_ADDR_EN
  assign head_word  = {2'b00, head.addr[ADDR_W-1:2]};
  assign head_misal = |head.addr[1:0];
`else
  assign head_word  = head.addr;
  assign head_misal = 1'b0;
`endif

  assign head_err = head_misal || (head_word >= ADDR_W'(DEPTH));

  // A new access starts from IDLE, or straight out of RESP on the handshake.
  assign issue = !empty && ((state == IDLE) || (state == RESP && bus.rsp_ready));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      mem_address  <= '0;
      mem_data     <= '0;
      mem_write_en <= 1'b0;
      mem_read_en  <= 1'b0;
      acc_err      <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) state <= ACCESS;
        end
        ACCESS: begin
          mem_write_en <= 1'b0;
          mem_read_en  <= 1'b0;
          rsp_valid_q  <= 1'b1;
          rsp_rdata_q  <= mem_read_en ? mem_read : '0;
          rsp_err_q    <= acc_err;
          state        <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            state       <= empty ? IDLE : ACCESS;
          end
        end
        default: state <= IDLE;
      endcase

      // Bad addresses still take the ACCESS cycle, just without strobes.
      if (issue) begin
        mem_address  <= head_word;
        mem_data     <= head.wdata;
        mem_write_en <= head.we && !head_err;
        mem_read_en  <= !head.we && !head_err;
        acc_err      <= head_err;
      end
    end
  end

endmodule
